// File: rtl/escape_pixel_dispatcher.sv
// escape_pixel_dispatcher: walks a frame in raster order, hands each escape count to the colour mapper and writes the RGB result to the frame buffer
module escape_pixel_dispatcher #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] esc_addr,
  input  logic [7:0]        esc_rdata,
  output logic [7:0]        map_escape,
  output logic              map_draw,
  input  logic              map_done,
  input  logic [7:0]        map_r,
  input  logic [7:0]        map_g,
  input  logic [7:0]        map_b,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, WRITE, RELEASE, ADVANCE, FRAME_DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0] esc_q, esc_d;
  logic [23:0] data_q, data_d;
  logic err_q, err_d;
  logic draw_q, draw_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic wait_hit;
  assign wait_hit    = wait_q == WAIT_MAX;
  assign esc_addr    = p_q;
  assign fb_addr     = p_q;
  assign map_escape  = esc_q;
  assign fb_data     = data_q;
  assign map_draw    = draw_q;
  assign fb_we       = we_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign timeout_err = err_q;
  // Next-state, per-pixel datapath and output decode; outputs follow the next state so they line up with it
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    wait_d  = wait_q;
    esc_d   = esc_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE:
        if (start) begin
          p_d     = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      FETCH: state_d = LATCH;
      LATCH: begin
        esc_d   = esc_rdata;
        wait_d  = '0;
        state_d = DRAW;
      end
      DRAW:
        if (map_done) begin
          data_d  = {map_r, map_g, map_b};
          state_d = WRITE;
        end else if (wait_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = WRITE;
        end else wait_d = wait_q + 1'b1;
      WRITE: begin
        wait_d  = '0;
        state_d = RELEASE;
      end
      RELEASE:
        if (!map_done) state_d = ADVANCE;
        else if (wait_hit) begin
          err_d   = 1'b1;
          state_d = ADVANCE;
        end else wait_d = wait_q + 1'b1;
      ADVANCE:
        if (p_q == LAST) state_d = FRAME_DONE;
        else begin
          p_d     = p_q + 1'b1;
          state_d = FETCH;
        end
      FRAME_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    draw_d = state_d == DRAW;
    we_d   = state_d == WRITE;
    busy_d = state_d != IDLE;
    done_d = state_d == FRAME_DONE;
  end
  // State and registered outputs; reset aborts any frame in progress at once
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      wait_q  <= '0;
      esc_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      draw_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      wait_q  <= wait_d;
      esc_q   <= esc_d;
      data_q  <= data_d;
      err_q   <= err_d;
      draw_q  <= draw_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_escape_pixel_dispatcher.sv
// tb_escape_pixel_dispatcher: directed frames against a behavioural colour mapper with a frame-buffer write scoreboard
module tb_escape_pixel_dispatcher;
  localparam int H = 4, V = 2, N = H * V, AW = 19, TO = 10;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;
  logic clk = 0, reset = 1, start = 0;
  logic [AW-1:0] esc_addr, fb_addr;
  logic [7:0] esc_rdata = 0, map_escape, map_r, map_g, map_b;
  logic map_draw, map_done, fb_we, busy, frame_done, timeout_err;
  logic [23:0] fb_data;
  int checks = 0, errors = 0;
  int cyc = 0, writes = 0, frames = 0, last_we = -1, exp_period = 0;
  int lat = 3, hold = 0, cnt = 0, hcnt = 0;
  bit never = 0, imm = 0;
  logic done_r = 0, prev_draw = 0, prev_done = 0;
  wr_t exp_q[$];

  escape_pixel_dispatcher #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .esc_addr(esc_addr), .esc_rdata(esc_rdata),
    .map_escape(map_escape), .map_draw(map_draw), .map_done(map_done),
    .map_r(map_r), .map_g(map_g), .map_b(map_b),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Escape RAM: synchronous read, content RAM[p] = p+1
  always @(posedge clk) esc_rdata <= 8'(esc_addr + 1);
  // Colour mapper: done after lat cycles of draw, held hold cycles after draw drops; imm answers in the same cycle
  assign map_done = imm ? map_draw : done_r;
  assign map_r = map_escape;
  assign map_g = ~map_escape;
  assign map_b = map_escape ^ 8'h55;
  always @(posedge clk)
    if (map_draw) begin
      hcnt <= 0;
      cnt  <= cnt + 1;
      if (!never && !imm && cnt >= lat - 1) done_r <= 1'b1;
    end else begin
      cnt <= 0;
      if (done_r) begin
        if (hcnt >= hold) done_r <= 1'b0;
        else hcnt <= hcnt + 1;
      end
    end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe, checks pixel spacing and stale-done redraws
  always @(negedge clk) begin
    wr_t e;
    if (fb_we) begin
      writes++;
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("fb_addr", 32'(fb_addr), 32'(e.addr));
        check("fb_data", 32'(fb_data), 32'(e.data));
      end
      if (last_we >= 0) check("write_period", cyc - last_we, exp_period);
      last_we = cyc;
    end
    if (frame_done) frames++;
    if (map_draw && !prev_draw) check("no_stale_done", 32'(prev_done), 0);
    prev_draw = map_draw;
    prev_done = map_done;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push_frame(bit to);
    wr_t e;
    logic [7:0] v;
    for (int p = 0; p < N; p++) begin
      v = 8'(p + 1);
      e.addr = AW'(p);
      e.data = to ? 24'h000000 : {v, ~v, v ^ 8'h55};
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(int period, bit to, bit mid, string tag);
    int n;
    exp_period = period;
    last_we = -1;
    writes = 0;
    frames = 0;
    push_frame(to);
    pulse_start();
    check({tag, "_busy_at_start"}, 32'(busy), 1);
    check({tag, "_err_cleared"}, 32'(timeout_err), 0);
    n = 0;
    while (!frame_done && n < 400) begin
      @(negedge clk);
      n++;
      start = mid && n == 30;
      if (mid && n == 30) check({tag, "_busy_mid"}, 32'(busy), 1);
    end
    start = 0;
    check({tag, "_frame_done_seen"}, 32'(frame_done), 1);
    @(negedge clk);
    check({tag, "_writes"}, writes, N);
    check({tag, "_frames"}, frames, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(to));
    exp_q.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_flags", {27'd0, map_draw, fb_we, busy, frame_done, timeout_err}, 0);
    check("rst_addr", 32'(esc_addr | fb_addr), 0);
    check("rst_data", {map_escape, fb_data}, 0);
    reset = 0;
    lat = 3; hold = 0;
    run_frame(9, 0, 0, "basic");
    hold = 4;
    run_frame(13, 0, 1, "hold");
    never = 1; hold = 0;
    run_frame(TO + 6, 1, 0, "timeout");
    never = 0; imm = 1;
    run_frame(6, 0, 0, "imm");
    imm = 0; lat = 3; hold = 0;
    exp_period = 9;
    last_we = -1;
    writes = 0;
    push_frame(0);
    pulse_start();
    n = 0;
    while (!(map_draw && esc_addr == 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_pixel3", 32'(map_draw && esc_addr == 3), 1);
    reset = 1;
    #1;
    check("rst_mid_draw", 32'(map_draw), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_we", 32'(fb_we), 0);
    check("rst_mid_writes", writes, 3);
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    check("post_rst_writes", writes, 3);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_draw", 32'(map_draw), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
